// File: rtl/dbg_mem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the debug memory port: FSM state encoding of the
// bridge, the "read" write-enable code, and the packed request record that is
// compared against and latched as the snapshot of the last accepted request.
// Also used by the UART debug monitor and by benches.
// ----------------------------------------------------------------------------
package dbg_pkg;

    // Bridge FSM states
    localparam logic [1:0] DBG_IDLE = 2'd0;   // CPU owns the memory bus
    localparam logic [1:0] DBG_BUSY = 2'd1;   // debug access on the bus
    localparam logic [1:0] DBG_DONE = 2'd2;   // one-cycle completion

    // A debug request with all byte enables clear is a word read
    localparam logic [3:0] DBG_WREN_READ = 4'h0;

    // Everything that identifies a debug request. Address bits [1:0] are not
    // part of it: accesses are whole words.
    typedef struct packed {
        logic [29:0] word_adr;
        logic [3:0]  wren;
        logic [31:0] wdata;
    } dbg_req_t;

    function automatic dbg_req_t pack_req(input logic [29:0] word_adr,
                                          input logic [3:0]  wren,
                                          input logic [31:0] wdata);
        dbg_req_t r;
        r.word_adr = word_adr;
        r.wren     = wren;
        r.wdata    = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dbg_mem_bridge_if.sv
// ----------------------------------------------------------------------------
// dbg_mem_bridge_if
// Debug memory port between a debug loader (master: UART monitor or bench)
// and the bridge (slave).
//   dbg_mem_op  request valid (level)       master -> slave
//   dbg_wren    byte enables, 0 = read      master -> slave
//   dbg_adr     byte address, word aligned  master -> slave
//   dbg_do      write data                  master -> slave
//   dbg_di      read data (held)            slave  -> master
//   dbg_ack     completion strobe           slave  -> master
//   dbg_err     timeout strobe              slave  -> master
// ----------------------------------------------------------------------------
interface dbg_mem_bridge_if;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        dbg_ack;
    logic        dbg_err;

    modport master (
        output dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        input  dbg_di, dbg_ack, dbg_err
    );

    modport slave (
        input  dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        output dbg_di, dbg_ack, dbg_err
    );
endinterface

// File: rtl/dbg_mem_bridge_req_detect.sv
// ----------------------------------------------------------------------------
// dbg_req_detect
// New-request detection for the debug port. A request is pending while the
// op level is high and it is either freshly raised, different from the last
// accepted request, or was already pending and not yet accepted. Accepting a
// request latches it into the snapshot, so a held, unchanged request runs once.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   op_i        debug request valid level
//   req_i       current request (word address, byte enables, data)
//   accept_i    bridge takes the pending request this cycle
//   pending_o   a new request is waiting
//   snap_o      snapshot of the last accepted request
// ----------------------------------------------------------------------------
module dbg_req_detect
    import dbg_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     op_i,
    input  dbg_req_t req_i,
    input  logic     accept_i,
    output logic     pending_o,
    output dbg_req_t snap_o
);

    logic     op_prev_q;
    logic     pend_q;
    dbg_req_t snap_q;
    dbg_req_t snap_d;

    // pend_q keeps a request pending even if the op edge has passed (e.g. the
    // op rose while the bridge was busy and the values match the snapshot).
    assign pending_o = op_i && (!op_prev_q || (req_i != snap_q) || pend_q);

    assign snap_d = accept_i ? req_i : snap_q;
    assign snap_o = snap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_prev_q <= 1'b0;
            pend_q    <= 1'b0;
            snap_q    <= '0;
        end else begin
            op_prev_q <= op_i;
            pend_q    <= pending_o && !accept_i;
            snap_q    <= snap_d;
        end
    end

endmodule

// File: rtl/dbg_mem_bridge.sv
// ----------------------------------------------------------------------------
// dbg_mem_bridge
// Responder for the SoC debug memory port. Sits between the CPU data bus and
// the shared memory bus, slots debug word reads / byte-masked writes in
// between CPU accesses (never breaking one in flight) and reports completion
// or timeout back to the debug master.
// Parameters:
//   TIMEOUT     cycles to wait for mem_ready before aborting with dbg_err
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   dbg         debug port (slave side): request in, read data/ack/err out
//   cpu_*       CPU data-bus request in, cpu_rdata/cpu_ready out
//   mem_*       memory request out (held until mem_ready), response in
// ----------------------------------------------------------------------------
module dbg_mem_bridge
    import dbg_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    dbg_mem_bridge_if.slave    dbg,
    input  logic               cpu_req,
    input  logic [3:0]         cpu_wren,
    input  logic [31:0]        cpu_adr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               mem_req,
    output logic [3:0]         mem_wren,
    output logic [31:0]        mem_adr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_act_q, cpu_act_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      di_q, di_d;

    logic             pending;
    logic             accept;
    logic             timeout_hit;
    dbg_req_t         cur_req;
    dbg_req_t         snap;
    logic             unused_adr_lsbs;

    assign unused_adr_lsbs = ^dbg.dbg_adr[1:0];
    assign cur_req = pack_req(dbg.dbg_adr[31:2], dbg.dbg_wren, dbg.dbg_do);

    dbg_req_detect u_detect (
        .clk       (clk),
        .reset     (reset),
        .op_i      (dbg.dbg_mem_op),
        .req_i     (cur_req),
        .accept_i  (accept),
        .pending_o (pending),
        .snap_o    (snap)
    );

    // A CPU access is "in flight" once it has been on the bus for a cycle
    // without completing. A CPU request that only just rose does not block
    // debug: debug wins that tie.
    assign accept = (state_q == DBG_IDLE) && pending && !cpu_act_q;

    assign timeout_hit = (state_q == DBG_BUSY) && !mem_ready
                         && (cnt_q == CNT_W'(TIMEOUT));

    // Next state and timeout counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DBG_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = DBG_BUSY;
            end
            DBG_BUSY: begin
                if (mem_ready || timeout_hit) state_d = DBG_DONE;
                else                          cnt_d   = cnt_q + CNT_W'(1);
            end
            DBG_DONE: state_d = DBG_IDLE;
            default:  state_d = DBG_IDLE;
        endcase
    end

    // Registered debug responses. Read data is captured on the completing
    // memory cycle so it is valid together with the ack in DONE.
    always_comb begin
        cpu_act_d = (state_q == DBG_IDLE) && mem_req && !mem_ready;
        ack_d     = (state_q == DBG_BUSY) && mem_ready;
        err_d     = timeout_hit;
        di_d      = di_q;
        if ((state_q == DBG_BUSY) && mem_ready && (snap.wren == DBG_WREN_READ))
            di_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DBG_IDLE;
            cnt_q     <= '0;
            cpu_act_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpu_act_q <= cpu_act_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            di_q      <= di_d;
        end
    end

    // Bus mux. In IDLE the CPU passes straight through, except in the cycle a
    // debug request is accepted, where the CPU request is held off so the
    // memory never starts it. Outside IDLE the CPU is stalled.
    always_comb begin
        mem_req   = 1'b0;
        mem_wren  = snap.wren;
        mem_adr   = {snap.word_adr, 2'b00};
        mem_wdata = snap.wdata;
        cpu_ready = 1'b0;
        if (state_q == DBG_IDLE) begin
            mem_req   = cpu_req && !accept;
            mem_wren  = cpu_wren;
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
            cpu_ready = mem_ready && !accept;
        end else if (state_q == DBG_BUSY) begin
            mem_req = 1'b1;
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign dbg.dbg_di  = di_q;
    assign dbg.dbg_ack = ack_q;
    assign dbg.dbg_err = err_q;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_dbg_mem_bridge
// Directed bench for dbg_mem_bridge with a small latency-programmable memory
// model. Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_dbg_mem_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbg_mem_bridge_if dbg_if();

    logic        cpu_req;
    logic [3:0]  cpu_wren;
    logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic [3:0]  mem_wren;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_ready;

    dbg_mem_bridge #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .dbg       (dbg_if),
        .cpu_req   (cpu_req),
        .cpu_wren  (cpu_wren),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_wren  (mem_wren),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Memory model: ready after mem_lat extra cycles of a held request,
    // never while mem_hang is set.
    logic [31:0] mem_arr [0:255];
    int          mem_lat  = 0;
    logic        mem_hang = 1'b0;
    int          mem_cnt  = 0;

    assign mem_ready = mem_req && !mem_hang && (mem_cnt >= mem_lat);
    assign mem_rdata = mem_ready ? mem_arr[mem_adr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_wren[b]) mem_arr[mem_adr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_cnt <= 0;
        end else if (mem_req) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    // Transaction monitor
    int          txn_cnt = 0;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_adr = '0;

    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            txn_cnt  <= txn_cnt + 1;
            last_adr <= mem_adr;
            $display("[TB] %0t mem txn adr=%h wren=%h wdata=%h rdata=%h",
                     $time, mem_adr, mem_wren, mem_wdata, mem_rdata);
        end
        if (dbg_if.dbg_ack) begin
            ack_cnt <= ack_cnt + 1;
            $display("[TB] %0t dbg ack di=%h", $time, dbg_if.dbg_di);
        end
        if (dbg_if.dbg_err) begin
            err_cnt <= err_cnt + 1;
            $display("[TB] %0t dbg err", $time);
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dbg(input logic op, input logic [3:0] wren,
                           input logic [31:0] adr, input logic [31:0] data);
        dbg_if.dbg_mem_op = op;
        dbg_if.dbg_wren   = wren;
        dbg_if.dbg_adr    = adr;
        dbg_if.dbg_do     = data;
    endtask

    task automatic set_cpu(input logic req, input logic [31:0] adr);
        cpu_req   = req;
        cpu_wren  = 4'h0;
        cpu_adr   = adr;
        cpu_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_dbg(1'b0, 4'h0, 32'h0, 32'h0);
        set_cpu(1'b1, 32'h20000);
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rst_pass_hi: mem_req=%b want 1", mem_req); end
        tests_run++;
        if (dbg_if.dbg_di !== 32'h0) begin tests_failed++; $display("FAIL rst_di: dbg_di=%h want 0", dbg_if.dbg_di); end
        tests_run++;
        if ({dbg_if.dbg_ack, dbg_if.dbg_err} !== 2'b00) begin tests_failed++; $display("FAIL rst_ack_err: %b want 00", {dbg_if.dbg_ack, dbg_if.dbg_err}); end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_pass_lo: mem_req=%b want 0", mem_req); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        int a0, t0;
        mem_lat = 0;
        a0 = ack_cnt;
        t0 = txn_cnt;
        step();
        set_dbg(1'b1, 4'hF, 32'h20000, 32'h0000006F);
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL sw_accept_cycle: mem_req=%b want 0", mem_req); end
        step();
        @(negedge clk);
        tests_run++;
        if ({mem_req, mem_wren, mem_adr, mem_wdata} !== {1'b1, 4'hF, 32'h20000, 32'h6F}) begin
            tests_failed++;
            $display("FAIL sw_mem_req: req=%b wren=%h adr=%h wdata=%h want 1 f 00020000 0000006f", mem_req, mem_wren, mem_adr, mem_wdata);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (dbg_if.dbg_ack !== 1'b1) begin tests_failed++; $display("FAIL sw_ack_n2: ack=%b want 1", dbg_if.dbg_ack); end
        step();
        @(negedge clk);
        tests_run++;
        if (dbg_if.dbg_ack !== 1'b0) begin tests_failed++; $display("FAIL sw_ack_n3: ack=%b want 0", dbg_if.dbg_ack); end
        repeat (96) step();
        tests_run++;
        if (txn_cnt - t0 !== 1) begin tests_failed++; $display("FAIL sw_once_txn: %0d txns want 1", txn_cnt - t0); end
        tests_run++;
        if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL sw_once_ack: %0d acks want 1", ack_cnt - a0); end
        tests_run++;
        if (mem_arr[0] !== 32'h6F) begin tests_failed++; $display("FAIL sw_mem: %h want 0000006f", mem_arr[0]); end
    endtask

    task automatic test_sequential_loader();
        int a0, t0;
        a0 = ack_cnt;
        t0 = txn_cnt;
        set_dbg(1'b1, 4'hF, 32'h20004, 32'h1);
        repeat (8) step();
        set_dbg(1'b1, 4'hF, 32'h20008, 32'h2);
        repeat (8) step();
        tests_run++;
        if (txn_cnt - t0 !== 2) begin tests_failed++; $display("FAIL seq_txns: %0d want 2", txn_cnt - t0); end
        tests_run++;
        if ({mem_arr[1], mem_arr[2], last_adr} !== {32'h1, 32'h2, 32'h20008}) begin
            tests_failed++;
            $display("FAIL seq_mem: %h %h last=%h want 00000001 00000002 00020008", mem_arr[1], mem_arr[2], last_adr);
        end
        set_dbg(1'b1, 4'h0, 32'h20004, 32'h2);
        repeat (8) step();
        tests_run++;
        if (dbg_if.dbg_di !== 32'h1) begin tests_failed++; $display("FAIL seq_readback: dbg_di=%h want 00000001", dbg_if.dbg_di); end
        tests_run++;
        if (ack_cnt - a0 !== 3) begin tests_failed++; $display("FAIL seq_acks: %0d want 3", ack_cnt - a0); end
    endtask

    task automatic test_byte_write();
        set_dbg(1'b1, 4'hF, 32'h20000, 32'hAABBCCDD);
        repeat (8) step();
        set_dbg(1'b1, 4'b0010, 32'h20000, 32'h00001100);
        repeat (8) step();
        tests_run++;
        if (mem_arr[0] !== 32'hAABB11DD) begin tests_failed++; $display("FAIL bw_mem: %h want aabb11dd", mem_arr[0]); end
        set_dbg(1'b1, 4'h0, 32'h20000, 32'h00001100);
        repeat (8) step();
        tests_run++;
        if (dbg_if.dbg_di !== 32'hAABB11DD) begin tests_failed++; $display("FAIL bw_read: dbg_di=%h want aabb11dd", dbg_if.dbg_di); end
        dbg_if.dbg_mem_op = 1'b0;
        step();
    endtask

    task automatic test_arbitration();
        int a0, viol;
        bit seen, served;
        mem_lat = 2;
        a0 = ack_cnt;
        set_cpu(1'b1, 32'h20004);
        step();
        set_dbg(1'b1, 4'hF, 32'h20008, 32'h55);
        @(negedge clk);
        tests_run++;
        if ({mem_req, mem_adr, cpu_ready} !== {1'b1, 32'h20004, 1'b0}) begin
            tests_failed++;
            $display("FAIL arb_cpu_hold: req=%b adr=%h rdy=%b want 1 00020004 0", mem_req, mem_adr, cpu_ready);
        end
        step();
        @(negedge clk);
        tests_run++;
        if ({cpu_ready, cpu_rdata} !== {1'b1, 32'h1}) begin
            tests_failed++;
            $display("FAIL arb_cpu_done: rdy=%b rdata=%h want 1 00000001", cpu_ready, cpu_rdata);
        end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL arb_accept_cycle: mem_req=%b want 0", mem_req); end
        step();
        @(negedge clk);
        tests_run++;
        if ({mem_req, mem_wren, mem_adr, mem_wdata} !== {1'b1, 4'hF, 32'h20008, 32'h55}) begin
            tests_failed++;
            $display("FAIL arb_dbg_start: req=%b wren=%h adr=%h wdata=%h want 1 f 00020008 00000055", mem_req, mem_wren, mem_adr, mem_wdata);
        end
        repeat (6) step();
        tests_run++;
        if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL arb_dbg_ack: %0d acks want 1", ack_cnt - a0); end

        // CPU and debug rise together: debug first, CPU stalled until after DONE
        set_cpu(1'b1, 32'h20000);
        set_dbg(1'b1, 4'hF, 32'h2000C, 32'h77);
        viol = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_ready) viol++;
            if (dbg_if.dbg_ack) seen = 1'b1;
        end
        tests_run++;
        if ({seen, viol} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL tie_dbg_first: ack_seen=%b cpu_ready_cycles=%0d want 1 0", seen, viol);
        end
        served = 1'b0;
        for (int i = 0; i < 20 && !served; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                served = 1'b1;
                tests_run++;
                if ({cpu_rdata, mem_arr[3]} !== {32'hAABB11DD, 32'h77}) begin
                    tests_failed++;
                    $display("FAIL tie_cpu_data: rdata=%h mem3=%h want aabb11dd 00000077", cpu_rdata, mem_arr[3]);
                end
            end
        end
        tests_run++;
        if (served !== 1'b1) begin tests_failed++; $display("FAIL tie_cpu_served: served=%b want 1", served); end
        step();
        cpu_req = 1'b0;
        mem_lat = 0;
        step();
    endtask

    task automatic test_timeout();
        int first, acks;
        bit served;
        first  = -1;
        acks   = 0;
        served = 1'b0;
        step();
        mem_hang = 1'b1;
        set_dbg(1'b1, 4'h0, 32'h20008, 32'h0);
        set_cpu(1'b1, 32'h20004);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dbg_if.dbg_ack) acks++;
            if (dbg_if.dbg_err && first < 0) begin
                first    = i;
                mem_hang = 1'b0;
            end
            if (cpu_ready && first >= 0) served = 1'b1;
        end
        tests_run++;
        if (first !== 10) begin tests_failed++; $display("FAIL to_err_cycle: err at %0d want 10", first); end
        tests_run++;
        if (acks !== 0) begin tests_failed++; $display("FAIL to_no_ack: %0d acks want 0", acks); end
        tests_run++;
        if (dbg_if.dbg_di !== 32'hAABB11DD) begin tests_failed++; $display("FAIL to_di_held: dbg_di=%h want aabb11dd", dbg_if.dbg_di); end
        tests_run++;
        if (served !== 1'b1) begin tests_failed++; $display("FAIL to_cpu_served: served=%b want 1", served); end
        step();
        cpu_req = 1'b0;
        mem_hang = 1'b0;
        step();
    endtask

    task automatic test_reset_midop();
        int a0, t0;
        step();
        mem_hang = 1'b1;
        set_dbg(1'b1, 4'hF, 32'h20010, 32'h99);
        step();
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rm_in_dbg: mem_req=%b want 1", mem_req); end
        a0 = ack_cnt;
        t0 = txn_cnt;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_req, dbg_if.dbg_ack, dbg_if.dbg_di} !== {1'b0, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rm_idle: req=%b ack=%b di=%h want 0 0 00000000", mem_req, dbg_if.dbg_ack, dbg_if.dbg_di);
        end
        mem_hang = 1'b0;
        repeat (10) step();
        tests_run++;
        if ({ack_cnt - a0, txn_cnt - t0} !== {32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL rm_reexec: acks=%0d txns=%0d want 1 1", ack_cnt - a0, txn_cnt - t0);
        end
        tests_run++;
        if (mem_arr[4] !== 32'h99) begin tests_failed++; $display("FAIL rm_mem: %h want 00000099", mem_arr[4]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_sequential_loader();
        test_byte_write();
        test_arbitration();
        test_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish within 50000 time units");
        $fatal(1, "watchdog");
    end

endmodule
